// File: rtl/ibex_pkg.sv
// Shared types for the IF skid stage: occupancy states, the per-entry record,
// and the single function that classifies and decorates an incoming instruction.
package ibex_pkg;

    typedef enum logic [1:0] {
        SkidEmpty = 2'd0,
        SkidOne   = 2'd1,
        SkidTwo   = 2'd2
    } if_skid_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        is_compressed;
        logic        err;
        logic        err_plus2;
    } if_skid_entry_t;

    // All per-instruction derivation happens here, on the input side, so the
    // output path is purely registered.
    function automatic if_skid_entry_t if_skid_build_entry(
        input logic [31:0] rdata,
        input logic [31:0] addr,
        input logic        err,
        input logic        err_plus2
    );
        if_skid_entry_t e;
        logic           comp;
        comp            = (rdata[1:0] != 2'b11);
        e.instr         = comp ? {16'h0000, rdata[15:0]} : rdata;
        e.pc            = addr;
        e.pc_next       = addr + (comp ? 32'd2 : 32'd4);
        e.is_compressed = comp;
        e.err           = err;
        e.err_plus2     = err_plus2 & ~comp;
        return e;
    endfunction

endpackage

// File: rtl/ibex_if_skid_stage.sv
// Two-entry skid buffer between the prefetch buffer and ID. The registered
// in_ready_o breaks the combinational ready path from decode back to the FIFO.
module ibex_if_skid_stage
    import ibex_pkg::*;
#(
    parameter bit ResetAll = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,

    // valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends on ready on either side.
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [31:0]    in_rdata_i,
    input  logic [31:0]    in_addr_i,
    input  logic           in_err_i,
    input  logic           in_err_plus2_i,

    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [31:0]    out_instr_o,
    output logic           out_is_compressed_o,
    output logic [31:0]    out_pc_o,
    output logic [31:0]    out_pc_next_o,
    output logic           out_err_o,
    output logic           out_err_plus2_o,

    output logic           busy_o,
    output if_skid_state_e dbg_state_o
);

    if_skid_state_e state_q, state_d;
    logic           in_ready_q;
    logic           busy_q;
    if_skid_entry_t head_q, head_d;
    if_skid_entry_t skid_q, skid_d;
    if_skid_entry_t in_entry;
    logic           in_fire;
    logic           out_fire;

    assign in_entry = if_skid_build_entry(in_rdata_i, in_addr_i, in_err_i, in_err_plus2_i);

    assign out_valid_o = busy_q & ~flush_i;
    assign in_fire     = in_valid_i & in_ready_q & ~flush_i;
    assign out_fire    = out_valid_o & out_ready_i;

    // Flush needs no explicit data case: it suppresses both fires, so the
    // entries simply hold while the state drops to empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = SkidEmpty;
        end else begin
            unique case (state_q)
                SkidEmpty: begin
                    if (in_fire) begin
                        state_d = SkidOne;
                        head_d  = in_entry;
                    end
                end
                SkidOne: begin
                    if (in_fire && out_fire) begin
                        head_d = in_entry;
                    end else if (in_fire) begin
                        state_d = SkidTwo;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = SkidEmpty;
                    end
                end
                SkidTwo: begin
                    if (out_fire) begin
                        state_d = SkidOne;
                        head_d  = skid_q;
                    end
                end
                default: state_d = SkidEmpty;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SkidEmpty;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SkidTwo);
            busy_q     <= (state_d != SkidEmpty);
        end
    end

    generate
        if (ResetAll) begin : g_dp_reset
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    head_q <= '0;
                    skid_q <= '0;
                end else begin
                    head_q <= head_d;
                    skid_q <= skid_d;
                end
            end
        end else begin : g_dp_noreset
            always_ff @(posedge clk_i) begin
                head_q <= head_d;
                skid_q <= skid_d;
            end
        end
    endgenerate

    assign in_ready_o          = in_ready_q;
    assign busy_o              = busy_q;
    assign dbg_state_o         = state_q;
    assign out_instr_o         = head_q.instr;
    assign out_is_compressed_o = head_q.is_compressed;
    assign out_pc_o            = head_q.pc;
    assign out_pc_next_o       = head_q.pc_next;
    assign out_err_o           = head_q.err;
    assign out_err_plus2_o     = head_q.err_plus2;

endmodule

// File: tb/tb_ibex_if_skid_stage.sv
// Directed bench for ibex_if_skid_stage: streaming, stall, flush, errors,
// PC wrap and synchronous reset, all against hand-computed values.
module tb_ibex_if_skid_stage;
    import ibex_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           flush_i;
    logic           in_valid_i;
    logic           in_ready_o;
    logic [31:0]    in_rdata_i;
    logic [31:0]    in_addr_i;
    logic           in_err_i;
    logic           in_err_plus2_i;
    logic           out_valid_o;
    logic           out_ready_i;
    logic [31:0]    out_instr_o;
    logic           out_is_compressed_o;
    logic [31:0]    out_pc_o;
    logic [31:0]    out_pc_next_o;
    logic           out_err_o;
    logic           out_err_plus2_o;
    logic           busy_o;
    if_skid_state_e dbg_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_if_skid_stage #(.ResetAll(1'b1)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .in_rdata_i          (in_rdata_i),
        .in_addr_i           (in_addr_i),
        .in_err_i            (in_err_i),
        .in_err_plus2_i      (in_err_plus2_i),
        .out_valid_o         (out_valid_o),
        .out_ready_i         (out_ready_i),
        .out_instr_o         (out_instr_o),
        .out_is_compressed_o (out_is_compressed_o),
        .out_pc_o            (out_pc_o),
        .out_pc_next_o       (out_pc_next_o),
        .out_err_o           (out_err_o),
        .out_err_plus2_o     (out_err_plus2_o),
        .busy_o              (busy_o),
        .dbg_state_o         (dbg_state_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] rdata, input logic [31:0] addr);
        in_valid_i = 1'b1;
        in_rdata_i = rdata;
        in_addr_i  = addr;
        #1;
    endtask

    task automatic idle_in();
        in_valid_i = 1'b0;
        in_rdata_i = 32'h0;
        in_addr_i  = 32'h0;
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; in_rdata_i = '0;
        in_addr_i = '0; in_err_i = 1'b0; in_err_plus2_i = 1'b0; out_ready_i = 1'b0;
        step(); step();
        rst_i = 1'b0; #1;

        // reset state
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_pc", out_pc_o, 0);
        chk("rst_pc_next", out_pc_next_o, 0);
        chk("rst_instr", out_instr_o, 0);
        chk("rst_err", out_err_o, 0);

        // streaming with decode always ready
        out_ready_i = 1'b1;
        offer(32'h0000_0413, 32'h100);
        step();
        offer(32'h0000_4501, 32'h104);
        chk("s1_valid", out_valid_o, 1);
        chk("s1_pc", out_pc_o, 32'h100);
        chk("s1_pc_next", out_pc_next_o, 32'h104);
        chk("s1_instr", out_instr_o, 32'h0000_0413);
        chk("s1_comp", out_is_compressed_o, 0);
        chk("s1_in_ready", in_ready_o, 1);
        step();
        offer(32'h00A0_0093, 32'h106);
        chk("s2_pc", out_pc_o, 32'h104);
        chk("s2_pc_next", out_pc_next_o, 32'h106);
        chk("s2_instr", out_instr_o, 32'h0000_4501);
        chk("s2_comp", out_is_compressed_o, 1);
        step();
        idle_in();
        chk("s3_valid", out_valid_o, 1);
        chk("s3_pc", out_pc_o, 32'h106);
        chk("s3_pc_next", out_pc_next_o, 32'h10A);
        chk("s3_comp", out_is_compressed_o, 0);
        step();
        chk("s4_valid", out_valid_o, 0);
        chk("s4_busy", busy_o, 0);

        // stall: three offered, two accepted
        out_ready_i = 1'b0;
        offer(32'h1111_1113, 32'h200);
        chk("st_ready0", in_ready_o, 1);
        step();
        offer(32'hABCD_0002, 32'h204);
        chk("st_ready1", in_ready_o, 1);
        step();
        offer(32'h2222_2223, 32'h206);
        chk("st_ready2", in_ready_o, 0);
        chk("st_pc_a", out_pc_o, 32'h200);
        step();
        chk("st_ready3", in_ready_o, 0);
        chk("st_hold_pc", out_pc_o, 32'h200);
        chk("st_busy", busy_o, 1);
        out_ready_i = 1'b1; #1;
        chk("st_rel_valid", out_valid_o, 1);
        step();
        chk("st_b_pc", out_pc_o, 32'h204);
        chk("st_b_pc_next", out_pc_next_o, 32'h206);
        chk("st_b_instr", out_instr_o, 32'h0000_0002);
        chk("st_b_ready", in_ready_o, 1);
        step();
        idle_in();
        chk("st_c_pc", out_pc_o, 32'h206);
        chk("st_c_instr", out_instr_o, 32'h2222_2223);
        chk("st_c_pc_next", out_pc_next_o, 32'h20A);
        step();
        chk("st_empty", out_valid_o, 0);

        // flush while holding two entries
        out_ready_i = 1'b0;
        offer(32'h3333_3333, 32'h300);
        step();
        offer(32'h0000_0005, 32'h304);
        step();
        chk("fl_ready_two", in_ready_o, 0);
        flush_i = 1'b1; out_ready_i = 1'b1;
        offer(32'h4444_4443, 32'h400);
        chk("fl_valid", out_valid_o, 0);
        chk("fl_busy", busy_o, 1);
        step();
        flush_i = 1'b0;
        idle_in();
        chk("fl_post_busy", busy_o, 0);
        chk("fl_post_valid", out_valid_o, 0);
        chk("fl_post_ready", in_ready_o, 1);
        offer(32'h0000_0008, 32'h500);
        step();
        idle_in();
        chk("fl_next_valid", out_valid_o, 1);
        chk("fl_next_pc", out_pc_o, 32'h500);
        step();
        chk("fl_drain", out_valid_o, 0);

        // fetch errors
        out_ready_i = 1'b0;
        in_err_i = 1'b1; in_err_plus2_i = 1'b1;
        offer(32'h1234_5673, 32'h600);
        step();
        offer(32'h0000_0001, 32'h604);
        chk("er_u_err", out_err_o, 1);
        chk("er_u_plus2", out_err_plus2_o, 1);
        out_ready_i = 1'b1; #1;
        step();
        in_err_i = 1'b0; in_err_plus2_i = 1'b0;
        idle_in();
        chk("er_c_err", out_err_o, 1);
        chk("er_c_plus2", out_err_plus2_o, 0);
        chk("er_c_comp", out_is_compressed_o, 1);
        chk("er_c_instr", out_instr_o, 32'h0000_0001);
        chk("er_c_pc", out_pc_o, 32'h604);
        step();

        // pc wrap-around
        offer(32'hFFFF_4501, 32'hFFFF_FFFE);
        step();
        offer(32'h0000_0413, 32'hFFFF_FFFC);
        chk("wr_c_pc", out_pc_o, 32'hFFFF_FFFE);
        chk("wr_c_next", out_pc_next_o, 32'h0);
        chk("wr_c_instr", out_instr_o, 32'h0000_4501);
        step();
        idle_in();
        chk("wr_u_next", out_pc_next_o, 32'h0);
        step();

        // reset in TWO
        out_ready_i = 1'b0;
        offer(32'h0000_0413, 32'h700);
        step();
        offer(32'h0000_0413, 32'h704);
        step();
        rst_i = 1'b1;
        offer(32'h0000_0002, 32'h800);
        step();
        rst_i = 1'b0;
        idle_in();
        chk("rs_valid", out_valid_o, 0);
        chk("rs_ready", in_ready_o, 1);
        chk("rs_busy", busy_o, 0);
        chk("rs_pc", out_pc_o, 0);
        step();
        chk("rs_still_empty", out_valid_o, 0);

        // reset in ONE while an input is acceptable: it must be dropped
        offer(32'h0000_0413, 32'h900);
        step();
        rst_i = 1'b1;
        offer(32'h0000_0002, 32'h904);
        chk("rs1_ready", in_ready_o, 1);
        step();
        rst_i = 1'b0;
        idle_in();
        chk("rs1_valid", out_valid_o, 0);
        chk("rs1_busy", busy_o, 0);
        step();
        chk("rs1_after", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
